trace_unloader: RTL

Drains the debug trace buffer after a capture and streams its contents bit-serially to the debug host. It sits between the trace buffer's read port and the JTAG-side shift logic. The host requests N words; the block issues one read pulse per word, captures the registered RAM output, and shifts each word out LSB-first, one bit per host strobe.

---
 rtl/trace_unloader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/trace_unloader.sv
// Trace buffer unloader: reads N words from the trace buffer and shifts them out LSB-first, one bit per host strobe.
// Optional CRC-8 trailer (poly 0x07) is enabled by defining TRACE_UNLOAD_CRC_EN.
module trace_unloader #(
    parameter int Fpay  = 32,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    input  logic             abort,
    input  logic             shift_en,
    output logic             tdo,
    output logic             tdo_valid,
    output logic             busy,
    output logic             done,
    output logic             tb_rd,
    input  logic [Fpay-1:0]  tb_dout
);

    localparam int BC_W = (Fpay > 1) ? $clog2(Fpay) : 1;
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(Fpay - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
`ifdef TRACE_UNLOAD_CRC_EN
        S_CRC   = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [Fpay-1:0]  shift_reg_q, shift_reg_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] words_left_q, words_left_d;
    logic             tdo_q, tdo_d;
    logic             tdo_valid_q, tdo_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tb_rd_q, tb_rd_d;
`ifdef TRACE_UNLOAD_CRC_EN
    logic [7:0]       crc_q, crc_d;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[7];
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        shift_reg_d  = shift_reg_q;
        bit_cnt_d    = bit_cnt_q;
        words_left_d = words_left_q;
`ifdef TRACE_UNLOAD_CRC_EN
        crc_d        = crc_q;
`endif
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
`ifdef TRACE_UNLOAD_CRC_EN
            crc_d   = 8'h00;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (num_words != '0) begin
                            words_left_d = num_words;
`ifdef TRACE_UNLOAD_CRC_EN
                            crc_d        = 8'h00;
`endif
                            state_d      = S_READ;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_READ: state_d = S_LOAD;
                S_LOAD: begin
                    shift_reg_d = tb_dout;
                    bit_cnt_d   = '0;
                    state_d     = S_SHIFT;
                end
                S_SHIFT: begin
                    if (shift_en) begin
                        shift_reg_d = shift_reg_q >> 1;
`ifdef TRACE_UNLOAD_CRC_EN
                        crc_d       = crc8_step(crc_q, shift_reg_q[0]);
`endif
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = '0;
                            // words_left stays at 1 on the final word rather than wrapping to 0
                            if (words_left_q != CNT_W'(1)) begin
                                words_left_d = words_left_q - CNT_W'(1);
                                state_d      = S_READ;
                            end else begin
`ifdef TRACE_UNLOAD_CRC_EN
                                state_d = S_CRC;
`else
                                state_d = S_DONE;
`endif
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BC_W'(1);
                        end
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
`ifdef TRACE_UNLOAD_CRC_EN
                S_CRC: begin
                    if (shift_en) begin
                        crc_d = {crc_q[6:0], 1'b0};
                        if (bit_cnt_q == BC_W'(7)) begin
                            bit_cnt_d = '0;
                            state_d   = S_DONE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BC_W'(1);
                        end
                    end else begin
                        state_d = S_CRC;
                    end
                end
`endif
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        case (state_d)
            S_SHIFT: tdo_d = shift_reg_d[0];
`ifdef TRACE_UNLOAD_CRC_EN
            S_CRC:   tdo_d = crc_d[7];
`endif
            default: tdo_d = 1'b0;
        endcase
`ifdef TRACE_UNLOAD_CRC_EN
        tdo_valid_d = (state_d == S_SHIFT) || (state_d == S_CRC);
`else
        tdo_valid_d = (state_d == S_SHIFT);
`endif
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        tb_rd_d = (state_d == S_READ);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shift_reg_q  <= '0;
            bit_cnt_q    <= '0;
            words_left_q <= '0;
            tdo_q        <= 1'b0;
            tdo_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tb_rd_q      <= 1'b0;
`ifdef TRACE_UNLOAD_CRC_EN
            crc_q        <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            shift_reg_q  <= shift_reg_d;
            bit_cnt_q    <= bit_cnt_d;
            words_left_q <= words_left_d;
            tdo_q        <= tdo_d;
            tdo_valid_q  <= tdo_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tb_rd_q      <= tb_rd_d;
`ifdef TRACE_UNLOAD_CRC_EN
            crc_q        <= crc_d;
`endif
        end
    end

    // abort must suppress the read strobe and the done pulse in the cycle it arrives
    assign tb_rd     = tb_rd_q & ~abort;
    assign done      = done_q & ~abort;
    assign tdo       = tdo_q;
    assign tdo_valid = tdo_valid_q;
    assign busy      = busy_q;

endmodule
